icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped instruction cache between the instruction-fetch unit and the memory controller.
//  Each line holds two 32-bit instructions (8 B), matching the controller's 64-bit fetch.
//  A hit returns an instruction one cycle after the request; a miss fetches one line through the controller.
//  clear_signal (branch mispredict) aborts any outstanding request.
// PARAMETERS
//  INDEX_BITS  6  line-index width; 2**INDEX_BITS lines, capacity 8*2**INDEX_BITS bytes
//  TAG_BITS    29-INDEX_BITS  derived (localparam): pc[31:3+INDEX_BITS]
// PORTS
//  clk_in            in   1   system clock
//  rst_in            in   1   reset; synchronous, active-high
//  rdy_in            in   1   0 = pause: all state and outputs hold
//  clear_signal      in   1   1 = mispredict flush of the in-flight fetch
//  fetch_req         in   1   level; fetch_pc held stable until fetch_valid or clear_signal
//  fetch_pc          in   32  instruction address; pc[1:0] ignored
//  fetch_instr       out  32  instruction word, valid only with fetch_valid
//  fetch_valid       out  1   single-cycle response pulse
//  mem_instr_signal  out  1   line-fetch request to memory controller
//  mem_instr_a       out  32  line address {pc[31:3],3'b000}; stable while mem_instr_signal=1
//  mem_instr_d       in   64  line data; bits [31:0] at addr+0, bits [63:32] at addr+4
//  mem_instr_done    in   1   one-cycle completion pulse from controller
//  hit_cnt, miss_cnt out  32  only with ICACHE_STATS_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all valid bits cleared; state=IDLE.
//   fetch_valid=0, fetch_instr=0, mem_instr_signal=0, mem_instr_a=0.
//  Field split: index=pc[3+INDEX_BITS-1:3]; word select=pc[2]; tag=pc[31:3+INDEX_BITS].
//  IDLE: when fetch_req=1, fetch_valid=0 and clear_signal=0, look up the line.
//   Hit (valid & tag match): next cycle fetch_valid=1, fetch_instr=word[pc[2]]; stay IDLE.
//   Miss: next cycle mem_instr_signal=1, mem_instr_a=line address; go to MISS.
//   No re-lookup in the cycle fetch_valid=1, so one request never gets two responses.
//  MISS: hold mem_instr_signal and mem_instr_a.
//   On mem_instr_done: write data, tag and valid=1 into the line.
//   Same edge: mem_instr_signal<=0; next cycle fetch_valid=1, fetch_instr=mem_instr_d word[pc[2]]; go to IDLE.
//   Dropping mem_instr_signal on the done edge is required: the controller rearms otherwise.
//  clear_signal=1, any state: fetch_valid<=0, mem_instr_signal<=0, state<=IDLE.
//   If mem_instr_done coincides with the clear, the line is still written but no response is given.
//  rdy_in=0: no state change (the array is not written, even if mem_instr_done=1), outputs hold.
//   rst_in has priority over rdy_in and clear_signal.
//  Reset mid-MISS: abandon the fetch; the controller is reset on the same edge.
//  Latency: hit = 1 cycle after the request is accepted; miss = 1 cycle after mem_instr_done.
//  Lines are never invalidated except by reset (no self-modifying-code support).
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//   Adds hit_cnt and miss_cnt: 32-bit, wrap at 2**32, reset to 0.
//   hit_cnt increments on every hit lookup; miss_cnt increments on every MISS entry.
//   A miss aborted by clear still counts.
//  ICACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package icache_pkg:
//   State encoding: IDLE=1'b0, MISS=1'b1.
//   LINE_BYTES=8, WORD_SEL_BIT=2, LINE_OFFSET_BITS=3.
//  Sub-module icache_array: valid/tag/data storage.
//   Combinational read by index; synchronous write on wr_en.
//   Valid bits cleared by rst_in.
//  Top level: FSM, hit compare, response and memory-request registers, optional counters.
// TESTING
//  1. Cold miss: req pc=0x0000_0010.
//     -> mem_instr_a=0x10; drive done with d=0x00A0_0093_0050_0513.
//     -> fetch_instr=0x0050_0513 one cycle after done.
//  2. Same-line hit: after test 1, req pc=0x14.
//     -> no mem request; fetch_valid=1 next cycle, fetch_instr=0x00A0_0093.
//  3. Conflict (INDEX_BITS=6): req pc=0x210 after test 1.
//     -> miss, mem_instr_a=0x210; then pc=0x10 misses again.
//  4. Clear during MISS: assert clear 3 cycles after the request.
//     -> mem_instr_signal=0 next cycle, no fetch_valid.
//     -> new req pc=0x40 fetches mem_instr_a=0x40.
//  5. rdy_in=0 for 5 cycles mid-MISS, done held high.
//     -> no change until rdy_in=1; then exactly one fetch_valid.
//  6. Sync reset after a fill.
//     -> previously hit pc=0x10 now misses.
//     -> with ICACHE_STATS_EN: hit_cnt=0, miss_cnt=0 right after reset.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, geometry constants and word-select helper for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_e;

  localparam int LINE_BYTES       = 8;
  localparam int WORD_SEL_BIT     = 2;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  // Picks the 32-bit instruction out of a 64-bit line; word 0 sits at the lower address.
  function automatic logic [31:0] select_word(input logic [63:0] line, input logic sel);
    if (sel) begin
      select_word = line[63:32];
    end else begin
      select_word = line[31:0];
    end
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by
// index, synchronous write, valid bits cleared by reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 32 - LINE_OFFSET_BITS - INDEX_BITS
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [63:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [63:0]           wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [63:0]         data_r [LINES];

  // Valid bits: only reset clears them, a fill sets one.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; they are qualified by the valid bit.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache (two instructions per line) between fetch and memory controller.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid,
  output logic        mem_instr_signal,
  output logic [31:0] mem_instr_a,
  input  logic [63:0] mem_instr_d,
  input  logic        mem_instr_done
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_BITS = 32 - LINE_OFFSET_BITS - INDEX_BITS;
  localparam int IDX_LO   = LINE_OFFSET_BITS;
  localparam int IDX_HI   = LINE_OFFSET_BITS + INDEX_BITS - 1;
  localparam int TAG_LO   = LINE_OFFSET_BITS + INDEX_BITS;

  icache_state_e       state_r, state_s;
  logic                fetch_valid_r, fetch_valid_s;
  logic [31:0]         fetch_instr_r, fetch_instr_s;
  logic                mem_sig_r, mem_sig_s;
  logic [31:0]         mem_a_r, mem_a_s;
  logic                word_sel_r, word_sel_s;
  logic                wr_en_s, hit_s, hit_evt_s, miss_evt_s;
  logic                rd_valid_s;
  logic [TAG_BITS-1:0] rd_tag_s;
  logic [63:0]         rd_data_s;
  logic                unused_pc_s;

  // Instruction alignment bits never reach the cache.
  assign unused_pc_s = ^fetch_pc[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (fetch_pc[IDX_HI:IDX_LO]),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_idx   (mem_a_r[IDX_HI:IDX_LO]),
    .wr_tag   (mem_a_r[31:TAG_LO]),
    .wr_data  (mem_instr_d)
  );

  assign hit_s = rd_valid_s && (rd_tag_s == fetch_pc[31:TAG_LO]);

  // Next-state and next-output logic; a fill completing under clear is still written.
  always_comb begin
    state_s       = state_r;
    fetch_valid_s = fetch_valid_r;
    fetch_instr_s = fetch_instr_r;
    mem_sig_s     = mem_sig_r;
    mem_a_s       = mem_a_r;
    word_sel_s    = word_sel_r;
    wr_en_s       = 1'b0;
    hit_evt_s     = 1'b0;
    miss_evt_s    = 1'b0;
    if (rdy_in && !rst_in) begin
      fetch_valid_s = 1'b0;
      wr_en_s       = (state_r == MISS) && mem_instr_done;
      if (clear_signal) begin
        mem_sig_s = 1'b0;
        state_s   = IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            // Skipping the lookup while a response is out keeps one request to one response.
            if (fetch_req && !fetch_valid_r) begin
              if (hit_s) begin
                fetch_valid_s = 1'b1;
                fetch_instr_s = select_word(rd_data_s, fetch_pc[WORD_SEL_BIT]);
                hit_evt_s     = 1'b1;
              end else begin
                mem_sig_s  = 1'b1;
                mem_a_s    = {fetch_pc[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                word_sel_s = fetch_pc[WORD_SEL_BIT];
                state_s    = MISS;
                miss_evt_s = 1'b1;
              end
            end else begin
              state_s = IDLE;
            end
          end
          MISS: begin
            if (mem_instr_done) begin
              mem_sig_s     = 1'b0;
              fetch_valid_s = 1'b1;
              fetch_instr_s = select_word(mem_instr_d, word_sel_r);
              state_s       = IDLE;
            end else begin
              mem_sig_s = 1'b1;
            end
          end
          default: begin
            mem_sig_s = 1'b0;
            state_s   = IDLE;
          end
        endcase
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r       <= IDLE;
      fetch_valid_r <= 1'b0;
      fetch_instr_r <= 32'h0000_0000;
      mem_sig_r     <= 1'b0;
      mem_a_r       <= 32'h0000_0000;
      word_sel_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      fetch_valid_r <= fetch_valid_s;
      fetch_instr_r <= fetch_instr_s;
      mem_sig_r     <= mem_sig_s;
      mem_a_r       <= mem_a_s;
      word_sel_r    <= word_sel_s;
    end
  end

  assign fetch_valid      = fetch_valid_r;
  assign fetch_instr      = fetch_instr_r;
  assign mem_instr_signal = mem_sig_r;
  assign mem_instr_a      = mem_a_r;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  // Lookup statistics; both wrap naturally at 2**32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (hit_evt_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_evt_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed self-checking bench for icache_direct_mapped; inputs driven and
// outputs sampled on the falling edge.
module tb_icache_direct_mapped;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal, fetch_req;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_valid, mem_instr_signal;
  logic [31:0] mem_instr_a;
  logic [63:0] mem_instr_d;
  logic        mem_instr_done;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk_in = ~clk_in;

  icache_direct_mapped dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear_signal     (clear_signal),
    .fetch_req        (fetch_req),
    .fetch_pc         (fetch_pc),
    .fetch_instr      (fetch_instr),
    .fetch_valid      (fetch_valid),
    .mem_instr_signal (mem_instr_signal),
    .mem_instr_a      (mem_instr_a),
    .mem_instr_d      (mem_instr_d),
    .mem_instr_done   (mem_instr_done)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; fetch_req = 1'b0;
    fetch_pc = 32'h0; mem_instr_d = 64'h0; mem_instr_done = 1'b0;
    @(negedge clk_in); @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    cmp_cnt++; if (fetch_instr !== 32'h0) begin err_cnt++; $display("FAIL rst_instr: got %h want 0", fetch_instr); end
    cmp_cnt++; if (mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL rst_memsig: got %b want 0", mem_instr_signal); end
    cmp_cnt++; if (mem_instr_a !== 32'h0) begin err_cnt++; $display("FAIL rst_mema: got %h want 0", mem_instr_a); end
`ifdef ICACHE_STATS_EN
    cmp_cnt++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin err_cnt++; $display("FAIL rst_stats: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
    rst_in = 1'b0;
  endtask

  task automatic test_cold_miss();
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h10) begin err_cnt++; $display("FAIL cold_req: got sig=%b a=%h want 1/00000010", mem_instr_signal, mem_instr_a); end
    cmp_cnt++; if (fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL cold_novalid: got %b want 0", fetch_valid); end
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h10) begin err_cnt++; $display("FAIL cold_hold: got sig=%b a=%h want 1/00000010", mem_instr_signal, mem_instr_a); end
    mem_instr_done = 1'b1; mem_instr_d = 64'h00A0_0093_0050_0513;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0050_0513) begin err_cnt++; $display("FAIL cold_resp: got v=%b i=%h want 1/00500513", fetch_valid, fetch_instr); end
    cmp_cnt++; if (mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL cold_drop: got %b want 0", mem_instr_signal); end
    mem_instr_done = 1'b0; fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL cold_pulse: got %b want 0", fetch_valid); end
  endtask

  task automatic test_same_line_hit();
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0014;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h00A0_0093) begin err_cnt++; $display("FAIL hit_resp: got v=%b i=%h want 1/00a00093", fetch_valid, fetch_instr); end
    cmp_cnt++; if (mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL hit_nomem: got %b want 0", mem_instr_signal); end
    fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL hit_pulse: got %b want 0", fetch_valid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0050_0513) begin err_cnt++; $display("FAIL b2b_first: got v=%b i=%h want 1/00500513", fetch_valid, fetch_instr); end
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_gap: got %b want 0", fetch_valid); end
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_second: got %b want 1", fetch_valid); end
    fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0 || mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle: got v=%b sig=%b want 0/0", fetch_valid, mem_instr_signal); end
  endtask

  task automatic test_conflict();
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0210;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h210) begin err_cnt++; $display("FAIL conf_req: got sig=%b a=%h want 1/00000210", mem_instr_signal, mem_instr_a); end
    mem_instr_done = 1'b1; mem_instr_d = 64'h1111_1111_2222_2222;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h2222_2222) begin err_cnt++; $display("FAIL conf_resp: got v=%b i=%h want 1/22222222", fetch_valid, fetch_instr); end
    mem_instr_done = 1'b0; fetch_req = 1'b0;
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h10 || fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL conf_evict: got sig=%b a=%h v=%b want 1/00000010/0", mem_instr_signal, mem_instr_a, fetch_valid); end
    mem_instr_done = 1'b1; mem_instr_d = 64'h00A0_0093_0050_0513;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0050_0513) begin err_cnt++; $display("FAIL conf_refill: got v=%b i=%h want 1/00500513", fetch_valid, fetch_instr); end
    mem_instr_done = 1'b0; fetch_req = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_clear_miss();
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0080;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h80) begin err_cnt++; $display("FAIL clr_req: got sig=%b a=%h want 1/00000080", mem_instr_signal, mem_instr_a); end
    @(negedge clk_in);
    @(negedge clk_in); clear_signal = 1'b1; fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b0 || fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL clr_abort: got sig=%b v=%b want 0/0", mem_instr_signal, fetch_valid); end
    clear_signal = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0 || mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL clr_quiet: got v=%b sig=%b want 0/0", fetch_valid, mem_instr_signal); end
    fetch_req = 1'b1; fetch_pc = 32'h0000_0040;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h40) begin err_cnt++; $display("FAIL clr_newreq: got sig=%b a=%h want 1/00000040", mem_instr_signal, mem_instr_a); end
    mem_instr_done = 1'b1; mem_instr_d = 64'hCAFE_BABE_DEAD_BEEF;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL clr_newresp: got v=%b i=%h want 1/deadbeef", fetch_valid, fetch_instr); end
    mem_instr_done = 1'b0; fetch_req = 1'b0;
    // A fill completing together with clear is stored but not answered.
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0088;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h88) begin err_cnt++; $display("FAIL clrdone_req: got sig=%b a=%h want 1/00000088", mem_instr_signal, mem_instr_a); end
    mem_instr_done = 1'b1; mem_instr_d = 64'h0BAD_F00D_1234_5678; clear_signal = 1'b1; fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0 || mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL clrdone_noresp: got v=%b sig=%b want 0/0", fetch_valid, mem_instr_signal); end
    mem_instr_done = 1'b0; clear_signal = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h0000_008C;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0BAD_F00D || mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL clrdone_written: got v=%b i=%h sig=%b want 1/0badf00d/0", fetch_valid, fetch_instr, mem_instr_signal); end
    fetch_req = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_rdy_pause();
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0104;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h100) begin err_cnt++; $display("FAIL rdy_req: got sig=%b a=%h want 1/00000100", mem_instr_signal, mem_instr_a); end
    rdy_in = 1'b0; mem_instr_done = 1'b1; mem_instr_d = 64'h5555_AAAA_0000_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      cmp_cnt++; if (fetch_valid !== 1'b0 || mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h100) begin err_cnt++; $display("FAIL rdy_hold%0d: got v=%b sig=%b a=%h want 0/1/00000100", i, fetch_valid, mem_instr_signal, mem_instr_a); end
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h5555_AAAA || mem_instr_signal !== 1'b0) begin err_cnt++; $display("FAIL rdy_resp: got v=%b i=%h sig=%b want 1/5555aaaa/0", fetch_valid, fetch_instr, mem_instr_signal); end
    mem_instr_done = 1'b0; fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL rdy_once: got %b want 0", fetch_valid); end
  endtask

  task automatic test_reset_after_fill();
`ifdef ICACHE_STATS_EN
    cmp_cnt++; if (hit_cnt !== 32'd4 || miss_cnt !== 32'd7) begin err_cnt++; $display("FAIL stats_run: got %0d/%0d want 4/7", hit_cnt, miss_cnt); end
`endif
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in);
    cmp_cnt++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || mem_instr_signal !== 1'b0 || mem_instr_a !== 32'h0) begin err_cnt++; $display("FAIL rst2_out: got v=%b i=%h sig=%b a=%h want all 0", fetch_valid, fetch_instr, mem_instr_signal, mem_instr_a); end
`ifdef ICACHE_STATS_EN
    cmp_cnt++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin err_cnt++; $display("FAIL rst2_stats: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
    rst_in = 1'b0;
    @(negedge clk_in); fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b1 || mem_instr_a !== 32'h10 || fetch_valid !== 1'b0) begin err_cnt++; $display("FAIL rst2_miss: got sig=%b a=%h v=%b want 1/00000010/0", mem_instr_signal, mem_instr_a, fetch_valid); end
    rst_in = 1'b1; fetch_req = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (mem_instr_signal !== 1'b0 || mem_instr_a !== 32'h0) begin err_cnt++; $display("FAIL rst2_abandon: got sig=%b a=%h want 0/00000000", mem_instr_signal, mem_instr_a); end
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line_hit();
    test_back_to_back();
    test_conflict();
    test_clear_miss();
    test_rdy_pause();
    test_reset_after_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
